// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM stage: FSM states, SRAM size codes, load/store opcodes.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

endpackage

// File: rtl/mem_align.sv
// Combinational load/store formatting: size and byte enables, store replication,
// alignment check and load byte/half selection with sign or zero extension.
module mem_align
  import mem_access_unit_pkg::*;
#(
  parameter int OP_W = 8
) (
  input  logic [OP_W-1:0] i_op,
  input  logic [1:0]      i_a,
  input  logic [31:0]     i_rt,
  input  logic [31:0]     i_rdata,
  output logic            o_is_load,
  output logic            o_is_store,
  output logic            o_misalign,
  output logic [1:0]      o_size,
  output logic [3:0]      o_wstrb,
  output logic [31:0]     o_wdata,
  output logic [31:0]     o_load_val
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_a, 3'b000} +: 8];
  assign w_half = i_a[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_is_load  = 1'b0;
    o_is_store = 1'b0;
    o_misalign = 1'b0;
    o_size     = SIZE_BYTE;
    o_wstrb    = 4'b0000;
    o_wdata    = 32'd0;
    o_load_val = i_rdata;
    case (i_op)
      OP_W'(EXE_LB_OP): begin
        o_is_load  = 1'b1;
        o_load_val = {{24{w_byte[7]}}, w_byte};
      end
      OP_W'(EXE_LBU_OP): begin
        o_is_load  = 1'b1;
        o_load_val = {24'd0, w_byte};
      end
      OP_W'(EXE_LH_OP): begin
        o_is_load  = 1'b1;
        o_size     = SIZE_HALF;
        o_misalign = i_a[0];
        o_load_val = {{16{w_half[15]}}, w_half};
      end
      OP_W'(EXE_LHU_OP): begin
        o_is_load  = 1'b1;
        o_size     = SIZE_HALF;
        o_misalign = i_a[0];
        o_load_val = {16'd0, w_half};
      end
      OP_W'(EXE_LW_OP): begin
        o_is_load  = 1'b1;
        o_size     = SIZE_WORD;
        o_misalign = |i_a;
      end
      OP_W'(EXE_SB_OP): begin
        o_is_store = 1'b1;
        o_wstrb    = 4'b0001 << i_a;
        o_wdata    = {4{i_rt[7:0]}};
      end
      OP_W'(EXE_SH_OP): begin
        o_is_store = 1'b1;
        o_size     = SIZE_HALF;
        o_misalign = i_a[0];
        o_wstrb    = 4'b0011 << i_a;
        o_wdata    = {2{i_rt[15:0]}};
      end
      OP_W'(EXE_SW_OP): begin
        o_is_store = 1'b1;
        o_size     = SIZE_WORD;
        o_misalign = |i_a;
        o_wstrb    = 4'hF;
        o_wdata    = i_rt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS MEM stage: one data-SRAM transaction per load/store, pass-through for other ops,
// alignment exceptions, and one registered result pulse per instruction toward WB.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OP_W   = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [OP_W-1:0]   ex_op,
  input  logic [ADDR_W-1:0] ex_alu_out,
  input  logic [31:0]       ex_rt_data,
  input  logic [4:0]        ex_wreg,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_result,
  output logic [4:0]        wb_wreg,
  output logic              mem_adel,
  output logic              mem_ades,
  output logic [ADDR_W-1:0] mem_badvaddr
);

  state_e            r_state, w_state_nxt;
  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_rt;
  logic [4:0]        r_wreg;
  logic              r_discard;
  logic              r_wb_valid, r_wb_nomem, r_adel, r_ades;
  logic [31:0]       r_wb_result;
  logic [4:0]        r_wb_wreg;
  logic [ADDR_W-1:0] r_badvaddr;

  logic              w_busy, w_accept, w_done, w_kill_wb, w_mem_op;
  logic [OP_W-1:0]   w_op;
  logic [1:0]        w_a, w_size;
  logic              w_is_load, w_is_store, w_misalign;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata, w_load_val;

  assign w_busy   = (r_state != ST_IDLE);
  assign ex_ready = ~w_busy;
  assign w_accept = ex_valid & ~w_busy & ~flush;

  // One formatter serves both phases: incoming op for the alignment check while idle,
  // captured op for store formatting and load extension while a transaction is open.
  assign w_op = w_busy ? r_op : ex_op;
  assign w_a  = w_busy ? r_addr[1:0] : ex_alu_out[1:0];

  mem_align #(.OP_W(OP_W)) u_align (
    .i_op       (w_op),
    .i_a        (w_a),
    .i_rt       (r_rt),
    .i_rdata    (data_rdata),
    .o_is_load  (w_is_load),
    .o_is_store (w_is_store),
    .o_misalign (w_misalign),
    .o_size     (w_size),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_load_val (w_load_val)
  );

  assign w_mem_op = w_is_load | w_is_store;
  assign w_done   = ((r_state == ST_REQ) & data_addr_ok & data_data_ok)
                  | ((r_state == ST_WAIT) & data_data_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_mem_op && !w_misalign) w_state_nxt = ST_REQ;
      ST_REQ:  if (data_addr_ok) w_state_nxt = data_data_ok ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (data_data_ok) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op   <= '0;
      r_addr <= '0;
      r_rt   <= '0;
      r_wreg <= '0;
    end else if (w_accept) begin
      r_op   <= ex_op;
      r_addr <= ex_alu_out;
      r_rt   <= ex_rt_data;
      r_wreg <= ex_wreg;
    end
  end

  // A flushed transaction still runs to data_ok so the SRAM handshake stays balanced.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              r_discard <= 1'b0;
    else if (w_done)          r_discard <= 1'b0;
    else if (w_busy && flush) r_discard <= 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wb_valid  <= 1'b0;
      r_wb_nomem  <= 1'b0;
      r_adel      <= 1'b0;
      r_ades      <= 1'b0;
      r_wb_result <= '0;
      r_wb_wreg   <= '0;
      r_badvaddr  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_adel     <= 1'b0;
      r_ades     <= 1'b0;
      if (w_accept && (!w_mem_op || w_misalign)) begin
        r_wb_valid  <= 1'b1;
        r_wb_nomem  <= 1'b1;
        r_wb_result <= 32'(ex_alu_out);
        r_wb_wreg   <= ex_wreg;
        if (w_misalign) begin
          r_adel     <= w_is_load;
          r_ades     <= w_is_store;
          r_badvaddr <= ex_alu_out;
        end
      end else if (w_done && !r_discard && !flush) begin
        r_wb_valid  <= 1'b1;
        r_wb_nomem  <= 1'b0;
        r_wb_result <= w_is_load ? w_load_val : 32'd0;
        r_wb_wreg   <= r_wreg;
      end
    end
  end

  // A flush arriving while a pass-through/error result is on the bus cancels it.
  assign w_kill_wb    = flush & r_wb_nomem;
  assign wb_valid     = r_wb_valid & ~w_kill_wb;
  assign mem_adel     = r_adel & ~w_kill_wb;
  assign mem_ades     = r_ades & ~w_kill_wb;
  assign wb_result    = r_wb_result;
  assign wb_wreg      = r_wb_wreg;
  assign mem_badvaddr = r_badvaddr;

  assign data_req   = (r_state == ST_REQ);
  assign data_wr    = w_busy & w_is_store;
  assign data_size  = w_busy ? w_size : 2'd0;
  assign data_addr  = w_busy ? r_addr : '0;
  assign data_wstrb = w_busy ? w_wstrb : 4'd0;
  assign data_wdata = w_busy ? w_wdata : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written flush/reset sequences,
// and randomized transactions checked against a byte-arithmetic reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam logic [7:0] ADDU = 8'b0010_0001;

  logic        clk, resetn, ex_valid, ex_ready, flush;
  logic [7:0]  ex_op;
  logic [31:0] ex_alu_out, ex_rt_data;
  logic [4:0]  ex_wreg;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        wb_valid, mem_adel, mem_ades;
  logic [31:0] wb_result, mem_badvaddr;
  logic [4:0]  wb_wreg;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(.ADDR_W(32), .OP_W(8)) dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op(ex_op), .ex_alu_out(ex_alu_out), .ex_rt_data(ex_rt_data), .ex_wreg(ex_wreg),
    .flush(flush), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .wb_valid(wb_valid), .wb_result(wb_result), .wb_wreg(wb_wreg),
    .mem_adel(mem_adel), .mem_ades(mem_ades), .mem_badvaddr(mem_badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          aok;
    int          dok;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        chk_res;
    logic [31:0] res;
    logic        adel;
    logic        ades;
    logic [4:0]  wreg;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, rt, rdata,
                              input int aok, dok, input logic req, wr, input logic [1:0] size,
                              input logic [3:0] wstrb, input logic [31:0] wdata,
                              input logic chk_res, input logic [31:0] res, input logic adel, ades);
    vec_t v;
    v.op = op; v.addr = addr; v.rt = rt; v.rdata = rdata; v.aok = aok; v.dok = dok;
    v.req = req; v.wr = wr; v.size = size; v.wstrb = wstrb; v.wdata = wdata;
    v.chk_res = chk_res; v.res = res; v.adel = adel; v.ades = ades; v.wreg = 5'd0;
    return v;
  endfunction

  // Reference: access width in bytes, alignment by modulo, byte lanes by shifting.
  function automatic vec_t model(input logic [7:0] op, input logic [31:0] addr, rt, rdata,
                                 input int aok, dok);
    vec_t   v;
    int     n, ofs;
    bit     ld, st, sg;
    longint mask, val;
    v = mk(op, addr, rt, rdata, aok, dok, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 1'b1, addr, 1'b0, 1'b0);
    n = 0; ld = 0; st = 0; sg = 0;
    case (op)
      EXE_LB_OP:  begin n = 1; ld = 1; sg = 1; end
      EXE_LBU_OP: begin n = 1; ld = 1; end
      EXE_LH_OP:  begin n = 2; ld = 1; sg = 1; end
      EXE_LHU_OP: begin n = 2; ld = 1; end
      EXE_LW_OP:  begin n = 4; ld = 1; end
      EXE_SB_OP:  begin n = 1; st = 1; end
      EXE_SH_OP:  begin n = 2; st = 1; end
      EXE_SW_OP:  begin n = 4; st = 1; end
      default:    n = 0;
    endcase
    if (n == 0) return v;
    ofs = int'(addr % 4);
    if ((addr % n) != 0) begin
      v.adel = ld; v.ades = st; v.chk_res = 1'b0;
      return v;
    end
    v.req  = 1'b1;
    v.wr   = st;
    v.size = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
    mask   = (64'sd1 <<< (8 * n)) - 1;
    if (st) begin
      v.chk_res = 1'b0;
      v.wstrb   = 4'(((1 << n) - 1) << ofs);
      for (int k = 0; k < 4 / n; k++)
        v.wdata = v.wdata | 32'((longint'(rt) & mask) <<< (8 * n * k));
    end else begin
      val = (longint'(rdata) >>> (8 * ofs)) & mask;
      if (sg && val >= (64'sd1 <<< (8 * n - 1))) val = val - (64'sd1 <<< (8 * n));
      v.res = 32'(val);
    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input bit stray);
    @(negedge clk);
    ex_valid = 1'b1; ex_op = v.op; ex_alu_out = v.addr; ex_rt_data = v.rt; ex_wreg = v.wreg;
    @(negedge clk);
    ex_valid = 1'b0; ex_op = 8'($urandom); ex_alu_out = $urandom; ex_rt_data = $urandom;
    if (!v.req) begin
      chk("noreq_data_req", 32'(data_req), 32'd0);
      chk("noreq_wb_valid", 32'(wb_valid), 32'd1);
      chk("noreq_adel", 32'(mem_adel), 32'(v.adel));
      chk("noreq_ades", 32'(mem_ades), 32'(v.ades));
      chk("noreq_wreg", 32'(wb_wreg), 32'(v.wreg));
      chk("noreq_ready", 32'(ex_ready), 32'd1);
      if (v.adel || v.ades) chk("badvaddr", mem_badvaddr, v.addr);
      if (v.chk_res) chk("passthru_result", wb_result, v.res);
    end else begin
      chk("req_data_req", 32'(data_req), 32'd1);
      chk("req_wr", 32'(data_wr), 32'(v.wr));
      chk("req_size", 32'(data_size), 32'(v.size));
      chk("req_addr", data_addr, v.addr);
      chk("req_wstrb", 32'(data_wstrb), 32'(v.wstrb));
      if (v.wr) chk("req_wdata", data_wdata, v.wdata);
      chk("req_ready", 32'(ex_ready), 32'd0);
      chk("req_wb_idle", 32'(wb_valid), 32'd0);
      for (int i = 0; i < v.aok; i++) begin
        data_data_ok = stray ? 1'($urandom % 2) : 1'b0;
        @(negedge clk);
        chk("req_hold", 32'(data_req), 32'd1);
        chk("req_hold_addr", data_addr, v.addr);
        chk("req_hold_wb", 32'(wb_valid), 32'd0);
      end
      data_addr_ok = 1'b1;
      data_data_ok = (v.dok == 0);
      data_rdata   = (v.dok == 0) ? v.rdata : $urandom;
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      if (v.dok > 0) begin
        chk("wait_data_req", 32'(data_req), 32'd0);
        chk("wait_wb", 32'(wb_valid), 32'd0);
        for (int i = 1; i < v.dok; i++) @(negedge clk);
        data_data_ok = 1'b1; data_rdata = v.rdata;
        @(negedge clk);
        data_data_ok = 1'b0;
      end
      data_rdata = $urandom;
      chk("done_wb_valid", 32'(wb_valid), 32'd1);
      chk("done_wreg", 32'(wb_wreg), 32'(v.wreg));
      chk("done_ready", 32'(ex_ready), 32'd1);
      if (v.chk_res) chk("load_result", wb_result, v.res);
    end
    @(negedge clk);
    chk("wb_pulse", 32'(wb_valid), 32'd0);
    data_data_ok = stray ? 1'($urandom % 2) : 1'b0;
    @(negedge clk);
    data_data_ok = 1'b0;
    chk("idle_stray", 32'(wb_valid), 32'd0);
    chk("idle_req", 32'(data_req), 32'd0);
  endtask

  vec_t        tbl[12];
  vec_t        v;
  logic [7:0]  ops[9];
  logic [31:0] a;
  int          r;

  initial begin
    ops = '{ADDU, EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    //           op          addr          rt            rdata         aok dok req wr size wstrb    wdata         cr res           adel ades
    tbl[0]  = mk(ADDU,       32'h00001234, 32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 2'd0, 4'h0,    32'h0,        1'b1, 32'h00001234, 1'b0, 1'b0);
    tbl[1]  = mk(EXE_SB_OP,  32'h00001003, 32'h000000AB, 32'h0,        0, 0, 1'b1, 1'b1, 2'd0, 4'b1000, 32'hABABABAB, 1'b0, 32'h0,        1'b0, 1'b0);
    tbl[2]  = mk(EXE_LB_OP,  32'h00002002, 32'h0,        32'h0080FF00, 3, 0, 1'b1, 1'b0, 2'd0, 4'h0,    32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 1'b0);
    tbl[3]  = mk(EXE_LBU_OP, 32'h00002002, 32'h0,        32'h0080FF00, 3, 0, 1'b1, 1'b0, 2'd0, 4'h0,    32'h0,        1'b1, 32'h00000080, 1'b0, 1'b0);
    tbl[4]  = mk(EXE_LW_OP,  32'h00003002, 32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 2'd0, 4'h0,    32'h0,        1'b0, 32'h0,        1'b1, 1'b0);
    tbl[5]  = mk(EXE_SH_OP,  32'h00003001, 32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 2'd0, 4'h0,    32'h0,        1'b0, 32'h0,        1'b0, 1'b1);
    tbl[6]  = mk(EXE_SH_OP,  32'h00002002, 32'h1234CDEF, 32'h0,        1, 2, 1'b1, 1'b1, 2'd1, 4'b1100, 32'hCDEFCDEF, 1'b0, 32'h0,        1'b0, 1'b0);
    tbl[7]  = mk(EXE_LH_OP,  32'h00004002, 32'h0,        32'h80017FFF, 0, 2, 1'b1, 1'b0, 2'd1, 4'h0,    32'h0,        1'b1, 32'hFFFF8001, 1'b0, 1'b0);
    tbl[8]  = mk(EXE_LHU_OP, 32'h00004002, 32'h0,        32'h80017FFF, 2, 0, 1'b1, 1'b0, 2'd1, 4'h0,    32'h0,        1'b1, 32'h00008001, 1'b0, 1'b0);
    tbl[9]  = mk(EXE_LW_OP,  32'h00005000, 32'h0,        32'hDEADBEEF, 1, 1, 1'b1, 1'b0, 2'd2, 4'h0,    32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    tbl[10] = mk(EXE_SW_OP,  32'h00006004, 32'h01234567, 32'h0,        0, 3, 1'b1, 1'b1, 2'd2, 4'hF,    32'h01234567, 1'b0, 32'h0,        1'b0, 1'b0);
    tbl[11] = mk(EXE_LB_OP,  32'h00007001, 32'h0,        32'h00007F00, 0, 0, 1'b1, 1'b0, 2'd0, 4'h0,    32'h0,        1'b1, 32'h0000007F, 1'b0, 1'b0);

    resetn = 1'b0; ex_valid = 1'b0; ex_op = 8'd0; ex_alu_out = 32'd0; ex_rt_data = 32'd0;
    ex_wreg = 5'd0; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_data_req", 32'(data_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wstrb", 32'(data_wstrb), 32'd0);
    chk("rst_wb_result", wb_result, 32'd0);
    chk("rst_adel", 32'(mem_adel), 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      v = tbl[i];
      v.wreg = 5'(i + 1);
      run_txn(v, 1'b0);
    end

    // Flush in IDLE cancels a pass-through result already on the bus, and blocks acceptance.
    @(negedge clk);
    ex_valid = 1'b1; ex_op = ADDU; ex_alu_out = 32'h55; ex_wreg = 5'd3;
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b1;
    #1 chk("flush_idle_kill", 32'(wb_valid), 32'd0);
    @(negedge clk);
    ex_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", 32'(wb_valid), 32'd0);
    chk("flush_blocks_ready", 32'(ex_ready), 32'd1);

    // Flush in REQ: request held until addr_ok, result discarded.
    @(negedge clk);
    ex_valid = 1'b1; ex_op = EXE_LW_OP; ex_alu_out = 32'h100; ex_wreg = 5'd4;
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b1;
    chk("flush_req_req", 32'(data_req), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_req_hold", 32'(data_req), 32'd1);
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h11112222;
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    chk("flush_req_nowb", 32'(wb_valid), 32'd0);
    chk("flush_req_ready", 32'(ex_ready), 32'd1);

    // Flush in WAIT: data_ok two cycles later is consumed silently.
    @(negedge clk);
    ex_valid = 1'b1; ex_op = EXE_LW_OP; ex_alu_out = 32'h200; ex_wreg = 5'd5;
    @(negedge clk);
    ex_valid = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    chk("flush_wait_req", 32'(data_req), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_wait_busy", 32'(ex_ready), 32'd0);
    @(negedge clk);
    chk("flush_wait_busy2", 32'(ex_ready), 32'd0);
    data_data_ok = 1'b1; data_rdata = 32'h33334444;
    @(negedge clk);
    data_data_ok = 1'b0;
    chk("flush_wait_nowb", 32'(wb_valid), 32'd0);
    chk("flush_wait_ready", 32'(ex_ready), 32'd1);
    @(negedge clk);
    chk("flush_wait_nowb2", 32'(wb_valid), 32'd0);

    // Asynchronous reset while in REQ, then a normal load.
    @(negedge clk);
    ex_valid = 1'b1; ex_op = EXE_LW_OP; ex_alu_out = 32'h300; ex_wreg = 5'd6;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rstreq_req_before", 32'(data_req), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rstreq_req_async", 32'(data_req), 32'd0);
    chk("rstreq_ready_async", 32'(ex_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    v = mk(EXE_LW_OP, 32'h304, 32'h0, 32'hCAFEF00D, 0, 1, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0,
           1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    v.wreg = 5'd7;
    run_txn(v, 1'b0);

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      r = $urandom_range(0, 3);
      if (r == 0) a[1:0] = 2'b00;
      else if (r == 1) a[0] = 1'b0;
      v = model(ops[$urandom_range(0, 8)], a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
      v.wreg = 5'($urandom);
      run_txn(v, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
